// File: rtl/dpi_fsm.sv
// Input data port FSM: moves words from the FX3 slave FIFO into the DPI FIFO,
// bursting while the watermark flag allows and falling back to flag-checked single reads.
module dpi_fsm #(
  parameter int RD_LAT       = 2,
  parameter int FLAG_LAT     = 3,
  parameter int MAX_PKT_SIZE = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        strt_i,
  output logic        done_o,
  output logic [15:0] words_o,
  input  logic        FLAGA_i,
  input  logic        FLAGB_i,
  output logic        SLRDn_o,
  output logic        SLOEn_o,
  input  logic [31:0] dq_i,
  output logic [31:0] dpi_dt_o,
  output logic        dpi_wr_o,
  input  logic        dpi_almost_full_i
);

  localparam int          WT_W    = (FLAG_LAT > 1) ? $clog2(FLAG_LAT) : 1;
  localparam logic [WT_W-1:0] WT_LAST = WT_W'(FLAG_LAT - 1);
  localparam logic [15:0] MAX_CNT = 16'(MAX_PKT_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    OE_EN,
    BURST_RD,
    SINGLE_RD,
    SINGLE_WT,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  logic [15:0]       rd_cnt;
  logic [15:0]       wr_cnt;
  logic [RD_LAT-1:0] rd_vld;
  logic [WT_W-1:0]   wt_cnt;

  logic room;
  logic burst_go;
  logic single_go;

  assign room      = (rd_cnt < MAX_CNT);
  assign burst_go  = FLAGB_i & ~dpi_almost_full_i & room;
  assign single_go = FLAGA_i & ~dpi_almost_full_i & room;

  // Outputs are registered, so each strobe decision is taken on the edge that
  // enters the cycle in which SLRDn_o is low; rd_cnt counts strobes committed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      SLRDn_o  <= 1'b1;
      SLOEn_o  <= 1'b1;
      done_o   <= 1'b0;
      dpi_wr_o <= 1'b0;
      dpi_dt_o <= '0;
      words_o  <= '0;
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      rd_vld   <= '0;
      wt_cnt   <= '0;
    end else begin
      rd_vld[0] <= ~SLRDn_o;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_vld[i] <= rd_vld[i-1];
      end
      dpi_wr_o <= rd_vld[RD_LAT-1];
      if (rd_vld[RD_LAT-1]) begin
        dpi_dt_o <= dq_i;
        wr_cnt   <= wr_cnt + 16'd1;
      end

      done_o  <= 1'b0;
      SLRDn_o <= 1'b1;

      case (state)
        IDLE: begin
          SLOEn_o <= 1'b1;
          rd_cnt  <= '0;
          wr_cnt  <= '0;
          wt_cnt  <= '0;
          if (strt_i) begin
            if (FLAGA_i && !dpi_almost_full_i) begin
              state   <= OE_EN;
              SLOEn_o <= 1'b0;
            end else begin
              state   <= DONE;
              done_o  <= 1'b1;
              words_o <= '0;
            end
          end
        end

        OE_EN: begin
          state   <= BURST_RD;
          SLOEn_o <= 1'b0;
          if (burst_go) begin
            SLRDn_o <= 1'b0;
            rd_cnt  <= rd_cnt + 16'd1;
          end
        end

        BURST_RD: begin
          SLOEn_o <= 1'b0;
          if (dpi_almost_full_i || !room) begin
            state <= DRAIN;
          end else if (!FLAGB_i) begin
            state <= SINGLE_RD;
          end else if (burst_go) begin
            SLRDn_o <= 1'b0;
            rd_cnt  <= rd_cnt + 16'd1;
          end
        end

        SINGLE_RD: begin
          SLOEn_o <= 1'b0;
          if (single_go) begin
            SLRDn_o <= 1'b0;
            rd_cnt  <= rd_cnt + 16'd1;
            wt_cnt  <= '0;
            state   <= SINGLE_WT;
          end else begin
            state <= DRAIN;
          end
        end

        // Give the FX3 flags time to reflect the single read before re-checking.
        SINGLE_WT: begin
          SLOEn_o <= 1'b0;
          if (wt_cnt == WT_LAST) begin
            if (FLAGB_i) begin
              state <= BURST_RD;
              if (burst_go) begin
                SLRDn_o <= 1'b0;
                rd_cnt  <= rd_cnt + 16'd1;
              end
            end else begin
              state <= SINGLE_RD;
            end
          end else begin
            wt_cnt <= wt_cnt + 1'b1;
          end
        end

        DRAIN: begin
          SLOEn_o <= 1'b0;
          if (rd_vld == '0 && SLRDn_o) begin
            state   <= DONE;
            SLOEn_o <= 1'b1;
            done_o  <= 1'b1;
            words_o <= wr_cnt;
          end
        end

        DONE: begin
          SLOEn_o <= 1'b1;
          state   <= IDLE;
        end

        default: begin
          state   <= IDLE;
          SLOEn_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dpi_fsm.sv
// Bench for dpi_fsm: an FX3 slave FIFO model feeds a scoreboard of expected
// words that is checked against every DPI FIFO write.
module tb_dpi_fsm;

  localparam int RD_LAT       = 2;
  localparam int FLAG_LAT     = 3;
  localparam int MAX_PKT_SIZE = 256;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        strt_i;
  logic        done_o;
  logic [15:0] words_o;
  logic        FLAGA_i;
  logic        FLAGB_i;
  logic        SLRDn_o;
  logic        SLOEn_o;
  logic [31:0] dq_i;
  logic [31:0] dpi_dt_o;
  logic        dpi_wr_o;
  logic        dpi_almost_full_i;

  int checks   = 0;
  int failures = 0;

  int fx3Load     = 0;
  int flagbThresh = RD_LAT + FLAG_LAT;
  int afAt        = 0;
  int flushReq    = 0;

  int fx3Taken  = 0;
  int strobeCnt = 0;
  int overRead  = 0;
  int oeViol    = 0;
  int wrCount   = 0;
  int cycleCnt  = 0;
  int curRun    = 0;
  int maxRun    = 0;
  int flushSeen = 0;
  logic [31:0] dqPipe [RD_LAT];
  logic [31:0] expQ [$];
  int strobeCycles [$];

  always #5 clk_i = ~clk_i;

  dpi_fsm #(
    .RD_LAT      (RD_LAT),
    .FLAG_LAT    (FLAG_LAT),
    .MAX_PKT_SIZE(MAX_PKT_SIZE)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .strt_i           (strt_i),
    .done_o           (done_o),
    .words_o          (words_o),
    .FLAGA_i          (FLAGA_i),
    .FLAGB_i          (FLAGB_i),
    .SLRDn_o          (SLRDn_o),
    .SLOEn_o          (SLOEn_o),
    .dq_i             (dq_i),
    .dpi_dt_o         (dpi_dt_o),
    .dpi_wr_o         (dpi_wr_o),
    .dpi_almost_full_i(dpi_almost_full_i)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, actual, actual, expected, expected);
    end
  endtask

  // FX3 model and write scoreboard, evaluated on the falling edge.
  always @(negedge clk_i) begin
    cycleCnt++;
    if (flushReq != flushSeen) begin
      expQ.delete();
      flushSeen = flushReq;
    end
    if (dpi_wr_o) begin
      wrCount++;
      if (expQ.size() == 0) checkOutput("wr_unexpected", 32'd1, 32'd0);
      else checkOutput("wr_data", dpi_dt_o, expQ.pop_front());
    end
    if (!SLRDn_o && SLOEn_o) oeViol++;
    dq_i = dqPipe[RD_LAT-1];
    for (int i = RD_LAT - 1; i > 0; i--) dqPipe[i] = dqPipe[i-1];
    dqPipe[0] = 32'hDEAD_BEEF;
    if (!SLRDn_o) begin
      strobeCnt++;
      curRun++;
      if (curRun > maxRun) maxRun = curRun;
      strobeCycles.push_back(cycleCnt);
      if (fx3Load - fx3Taken <= 0) begin
        overRead++;
      end else begin
        dqPipe[0] = 32'(fx3Taken);
        expQ.push_back(32'(fx3Taken));
        fx3Taken++;
      end
    end else begin
      curRun = 0;
    end
    FLAGA_i           = (fx3Load - fx3Taken) > 0;
    FLAGB_i           = (fx3Load - fx3Taken) > flagbThresh;
    dpi_almost_full_i = (afAt > 0) && (strobeCnt >= afAt);
  end

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input int words, input int thresh, input int afAfter);
    fx3Load     = fx3Taken + words;
    flagbThresh = thresh;
    afAt        = (afAfter > 0) ? strobeCnt + afAfter : 0;
    tick();
    strt_i = 1'b1;
    tick();
    strt_i = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget, output int lat);
    lat = 0;
    while (!done_o && lat < budget) begin
      tick();
      lat++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done_o), 32'd1);
    tick();
    checkOutput({tag, "_done_pulse"}, 32'(done_o), 32'd0);
  endtask

  task automatic checkTxn(input string tag, input int strobeBase, input int overBase, input int oeBase,
                          input int expWords);
    checkOutput({tag, "_words"}, 32'(words_o), 32'(expWords));
    checkOutput({tag, "_strobes"}, 32'(strobeCnt - strobeBase), 32'(expWords));
    checkOutput({tag, "_words_eq_strobes"}, 32'(words_o), 32'(strobeCnt - strobeBase));
    checkOutput({tag, "_sb_empty"}, 32'(expQ.size()), 32'd0);
    checkOutput({tag, "_over_read"}, 32'(overRead - overBase), 32'd0);
    checkOutput({tag, "_rd_without_oe"}, 32'(oeViol - oeBase), 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_slrdn"}, 32'(SLRDn_o), 32'd1);
    checkOutput({tag, "_sloen"}, 32'(SLOEn_o), 32'd1);
    checkOutput({tag, "_done"}, 32'(done_o), 32'd0);
    checkOutput({tag, "_wr"}, 32'(dpi_wr_o), 32'd0);
    checkOutput({tag, "_dt"}, dpi_dt_o, 32'd0);
    checkOutput({tag, "_words"}, 32'(words_o), 32'd0);
  endtask

  initial begin
    int lat, sBase, oBase, eBase, cBase, wBase, waitCnt;
    rst_i  = 1'b1;
    strt_i = 1'b0;
    repeat (3) tick();
    checkResetOutputs("reset");
    rst_i = 1'b0;
    tick();

    $display("[TB] empty transaction");
    sBase = strobeCnt; oBase = overRead; eBase = oeViol;
    applyStimulus(0, RD_LAT + FLAG_LAT, 0);
    waitDone("empty", 20, lat);
    checkOutput("empty_latency", 32'(lat), 32'd0);
    checkTxn("empty", sBase, oBase, eBase, 0);

    $display("[TB] full burst");
    sBase = strobeCnt; oBase = overRead; eBase = oeViol;
    applyStimulus(1000, RD_LAT + FLAG_LAT, 0);
    waitDone("burst", 1000, lat);
    checkTxn("burst", sBase, oBase, eBase, MAX_PKT_SIZE);
    checkOutput("burst_contiguous", 32'(maxRun), 32'(MAX_PKT_SIZE));

    $display("[TB] single-word mode");
    sBase = strobeCnt; oBase = overRead; eBase = oeViol; cBase = strobeCycles.size();
    applyStimulus(5, RD_LAT + FLAG_LAT, 0);
    waitDone("single", 200, lat);
    checkTxn("single", sBase, oBase, eBase, 5);
    for (int i = cBase + 1; i < strobeCycles.size(); i++)
      checkOutput("single_spacing", 32'(strobeCycles[i] - strobeCycles[i-1]), 32'(1 + FLAG_LAT));

    $display("[TB] almost-full stop");
    sBase = strobeCnt; oBase = overRead; eBase = oeViol;
    applyStimulus(40, RD_LAT + FLAG_LAT, 20);
    waitDone("afull", 300, lat);
    checkTxn("afull", sBase, oBase, eBase, 20);

    $display("[TB] watermark drop mid-burst");
    sBase = strobeCnt; oBase = overRead; eBase = oeViol;
    applyStimulus(30, 7, 0);
    waitDone("wmdrop", 400, lat);
    checkTxn("wmdrop", sBase, oBase, eBase, 30);

    $display("[TB] reset mid-burst");
    sBase = strobeCnt;
    applyStimulus(1000, RD_LAT + FLAG_LAT, 0);
    waitCnt = 0;
    while (strobeCnt - sBase < 10 && waitCnt < 100) begin
      tick();
      waitCnt++;
    end
    checkOutput("rst_strobes_reached", 32'(strobeCnt - sBase >= 10), 32'd1);
    rst_i = 1'b1;
    tick();
    checkResetOutputs("midrst");
    rst_i = 1'b0;
    flushReq++;
    wBase = wrCount;
    sBase = strobeCnt;
    repeat (10) tick();
    checkOutput("midrst_no_writes", 32'(wrCount - wBase), 32'd0);
    checkOutput("midrst_no_strobes", 32'(strobeCnt - sBase), 32'd0);

    $display("[TB] transaction after reset");
    sBase = strobeCnt; oBase = overRead; eBase = oeViol;
    applyStimulus(12, RD_LAT + FLAG_LAT, 0);
    waitDone("postrst", 300, lat);
    checkTxn("postrst", sBase, oBase, eBase, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
